// File: rtl/prediction_stat_table.sv
// prediction_stat_table
//
// Storage stage downstream of the prediction writer. One instance per predictor
// flavour (SP, LHP, GHP). Each (addr, index) slot holds a 3-bit signed trend
// counter and a STAT_COUNTER_WIDTH-bit signed stat counter. The writer owns all
// counter arithmetic; this table stores values verbatim.
//
// Optional feature: define PREDICTION_TABLE_BYPASS_EN to forward same-cycle
// writes (and same-cycle clears of the stat field) onto the read outputs.
// Without it, the read outputs show storage only and writes appear next cycle.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   clear_en1, clear_en2       clear all stat fields (trend fields untouched)
//   WR_en1 / WR_en2            write port enables (port 2 wins on same slot)
//   WR_addr*, WR_index*        write slot select {addr, index}
//   WR_trend_count*            trend value to store
//   WR_stat_count*             stat value to store
//   RD_addr, RD_index          combinational read slot select
//   RD_trend_count             trend of the addressed slot
//   RD_stat_count              stat of the addressed slot
//   clear_busy                 one-cycle pulse in the cycle after a clear

module prediction_stat_table #(
    parameter int ADDR_WIDTH         = 3,
    parameter int INDEX_WIDTH        = 2,
    parameter int STAT_COUNTER_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear_en1,
    input  logic                                 clear_en2,
    input  logic                                 WR_en1,
    input  logic                                 WR_en2,
    input  logic        [ADDR_WIDTH-1:0]         WR_addr1,
    input  logic        [ADDR_WIDTH-1:0]         WR_addr2,
    input  logic        [INDEX_WIDTH-1:0]        WR_index1,
    input  logic        [INDEX_WIDTH-1:0]        WR_index2,
    input  logic signed [2:0]                    WR_trend_count1,
    input  logic signed [2:0]                    WR_trend_count2,
    input  logic signed [STAT_COUNTER_WIDTH-1:0] WR_stat_count1,
    input  logic signed [STAT_COUNTER_WIDTH-1:0] WR_stat_count2,
    input  logic        [ADDR_WIDTH-1:0]         RD_addr,
    input  logic        [INDEX_WIDTH-1:0]        RD_index,
    output logic signed [2:0]                    RD_trend_count,
    output logic signed [STAT_COUNTER_WIDTH-1:0] RD_stat_count,
    output logic                                 clear_busy
);

    localparam int SLOT_WIDTH = ADDR_WIDTH + INDEX_WIDTH;
    localparam int DEPTH      = 2 ** SLOT_WIDTH;

    logic signed [2:0]                    trend_mem [DEPTH];
    logic signed [STAT_COUNTER_WIDTH-1:0] stat_mem  [DEPTH];

    logic [SLOT_WIDTH-1:0] wr_slot1;
    logic [SLOT_WIDTH-1:0] wr_slot2;
    logic [SLOT_WIDTH-1:0] rd_slot;
    logic                  clear_any;

    assign wr_slot1  = {WR_addr1, WR_index1};
    assign wr_slot2  = {WR_addr2, WR_index2};
    assign rd_slot   = {RD_addr, RD_index};
    assign clear_any = clear_en1 | clear_en2;

    // Port 2 is written after port 1 so that on a slot collision its
    // non-blocking assignment is the one that sticks. A clear overrides any
    // stat write in the same cycle, but trend writes still land.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                trend_mem[i] <= '0;
                stat_mem[i]  <= '0;
            end
            clear_busy <= 1'b0;
        end else begin
            clear_busy <= clear_any;

            if (WR_en1) trend_mem[wr_slot1] <= WR_trend_count1;
            if (WR_en2) trend_mem[wr_slot2] <= WR_trend_count2;

            if (clear_any) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stat_mem[i] <= '0;
                end
            end else begin
                if (WR_en1) stat_mem[wr_slot1] <= WR_stat_count1;
                if (WR_en2) stat_mem[wr_slot2] <= WR_stat_count2;
            end
        end
    end

`ifdef PREDICTION_TABLE_BYPASS_EN
    // Forwarding mirrors the write priority: port 2, then port 1, then storage.
    // A pending clear zeroes the forwarded stat just as it will in storage.
    always_comb begin
        RD_trend_count = trend_mem[rd_slot];
        RD_stat_count  = stat_mem[rd_slot];
        if (WR_en2 && (wr_slot2 == rd_slot)) begin
            RD_trend_count = WR_trend_count2;
            RD_stat_count  = WR_stat_count2;
        end else if (WR_en1 && (wr_slot1 == rd_slot)) begin
            RD_trend_count = WR_trend_count1;
            RD_stat_count  = WR_stat_count1;
        end
        if (clear_any) begin
            RD_stat_count = '0;
        end
    end
`else
    assign RD_trend_count = trend_mem[rd_slot];
    assign RD_stat_count  = stat_mem[rd_slot];
`endif

endmodule
